// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks.
// Holds the response owner tag and one tracker entry.
package riscv_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } resp_ent_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/resp_tracker.sv
// Shift register of in-flight reads; routes the tail to its owner.
// Ports: clk/rst, ins_valid/ins_owner (head load), kill, if_rvalid/d_rvalid.
module resp_tracker
  import riscv_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ins_valid,
  input  owner_t ins_owner,
  input  logic   kill,
  output logic   if_rvalid,
  output logic   d_rvalid
);

  resp_ent_t [LATENCY-1:0] ent_q;
  resp_ent_t [LATENCY-1:0] ent_d;
  resp_ent_t               tail;

  always_comb begin
    ent_d          = ent_q;
    ent_d[0].valid = ins_valid;
    ent_d[0].owner = ins_owner;
    for (int i = 1; i < LATENCY; i++) begin
      ent_d[i] = ent_q[i-1];
    end
    // A redirect also drops the fetch entering the head this cycle.
    for (int i = 0; i < LATENCY; i++) begin
      if (kill && ent_d[i].owner == OWNER_IF) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign tail = ent_q[LATENCY-1];

  // Kill masks the tail combinationally so no stale fetch data escapes.
  assign if_rvalid = tail.valid &
                     (tail.owner == OWNER_IF) & ~kill;
  assign d_rvalid  = tail.valid &
                     (tail.owner == OWNER_D);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates imem/dmem onto one fixed-latency memory port.
// Ports: if_* fetch side, d_* data side, mem_* memory side.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam logic [STREAK_W-1:0] MAX_S =
    STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                fetch_turn;
  logic                ins_valid;
  owner_t              ins_owner;

  assign fetch_turn = (streak_q == MAX_S);

  // Data wins unless fetch has waited through a full streak.
  assign d_gnt_o  = ~rst_i & d_req_i &
                    ~(if_req_i & fetch_turn);
  assign if_gnt_o = ~rst_i & if_req_i &
                    (~d_req_i | fetch_turn);

  assign mem_req_o = if_gnt_o | d_gnt_o;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt_o) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt_o) begin
      mem_be_o    = '1;
      mem_addr_o  = if_addr_i;
    end
  end

  // Streak only counts data grants that made a fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt_o) begin
      streak_d = '0;
    end else if (d_gnt_o && streak_q != MAX_S) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign ins_valid = if_gnt_o | (d_gnt_o & ~d_we_i);
  assign ins_owner = if_gnt_o ? OWNER_IF : OWNER_D;

  resp_tracker #(
    .LATENCY (LATENCY)
  ) u_trk (
    .clk       (clk_i),
    .rst       (rst_i),
    .ins_valid (ins_valid),
    .ins_owner (ins_owner),
    .kill      (if_kill_i),
    .if_rvalid (if_rvalid_o),
    .d_rvalid  (d_rvalid_o)
  );

  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the core's instruction-fetch port and data port, for unified-memory builds.
- Grants at most one request per cycle.
- Data accesses have priority; a streak counter prevents fetch starvation.
- Tracks in-flight reads and routes each read response back to the requester that issued it.
- Sits between the core's imem/dmem ports and the memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LATENCY, 1, memory read latency in cycles; legal range 1..4
MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is waiting; legal range 1..15

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
if_req_i  in  1  fetch read request; held with if_addr_i until granted
if_addr_i  in  ADDR_W  fetch address
if_kill_i  in  1  discard all in-flight fetch responses (pc redirect)
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DATA_W  fetch read data
d_req_i  in  1  data request; held with all data-side inputs until granted
d_we_i  in  1  1 = write, 0 = read
d_be_i  in  DATA_W/8  write byte enables
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_gnt_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  data read data valid
d_rdata_o  out  DATA_W  data read data
mem_req_o  out  1  memory access this cycle
mem_we_o  out  1  memory write
mem_be_o  out  DATA_W/8  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid LATENCY cycles after a read request

Behaviour:
Grant (combinational, same cycle as request):
- Only d_req_i: grant data.
- Only if_req_i: grant fetch.
- Both: grant fetch if streak == MAX_D_STREAK, else grant data.
- Exactly one of if_gnt_o / d_gnt_o is high at a time; neither when there is no request.

Memory outputs:
- mem_req_o = if_gnt_o | d_gnt_o.
- mem_* are muxed from the granted requester.
- A fetch drives mem_we_o=0 and mem_be_o='1.
- With no grant: mem_we_o=0, mem_be_o=0, mem_addr_o and mem_wdata_o=0.

Streak counter (4 bits, reset 0):
- Increments on a data grant while if_req_i=1.
- Clears on a fetch grant, or in any cycle with if_req_i=0.
- Saturates at MAX_D_STREAK.

Response tracker: LATENCY-deep shift register of {valid, owner}, all entries reset to invalid.
- Each cycle the head loads valid = (grant & read), owner = granted requester; writes insert an invalid entry.
- Tail entry valid with owner IF: if_rvalid_o=1. Tail valid with owner D: d_rvalid_o=1.
- if_rdata_o and d_rdata_o both mirror mem_rdata_i; they are meaningful only with the matching rvalid.
- Response latency is exactly LATENCY cycles after the grant; back-to-back grants give back-to-back responses.

if_kill_i:
- Invalidates every IF-owned entry in the tracker, including one being inserted that cycle.
- The tail entry is invalidated combinationally, so if_rvalid_o=0 in the kill cycle.
- D entries are unaffected.
- if_gnt_o in the kill cycle is still issued; the kill discards that fetch's response.

Reset:
- Asynchronous, effective mid-operation.
- All in-flight responses are dropped and the counter clears.
- rvalid outputs are 0 during and after reset until a new read completes.
- Grant outputs follow the inputs combinationally, but are forced to 0 while rst_i=1.

Decomposition:
- riscv_pkg gains owner_t enum {OWNER_IF, OWNER_D}.
- Sub-module resp_tracker (parameter LATENCY): holds the shift register, kill logic and rvalid decoding.
- mem_arbiter holds the grant logic, streak counter and muxing.

Test Plan:
1. LATENCY=1, only if_req_i=1 with addr 0x100, memory returns 0xDEADBEEF -> if_gnt_o=1 in cycle 0; if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 1; d_rvalid_o stays 0.
2. Both requests held for 10 cycles, MAX_D_STREAK=4, every data access a read -> grant sequence D,D,D,D,IF,D,D,D,D,IF; rvalids follow the same order one cycle later.
3. Data write to 0x200 with be=4'b0011 and wdata=0x1234ABCD -> mem_we_o=1, mem_be_o=0011, mem_addr_o=0x200 in the grant cycle; no d_rvalid_o ever follows.
4. LATENCY=3, fetches granted in cycles 0,1,2, if_kill_i=1 in cycle 2 -> no if_rvalid_o in cycles 3-5. A data read granted in cycle 1 (fetches shifted accordingly) still returns d_rvalid_o in cycle 4.
5. rst_i asserted for one cycle while two reads are in flight (LATENCY=2) -> no rvalid in the following 3 cycles; streak counter reads 0; fresh fetch grant is accepted immediately after reset release.
6. Fetch granted (LATENCY=1) in the same cycle as if_kill_i=1 -> if_rvalid_o=0 in the next cycle.
